// File: rtl/match_pkg.sv
// Shared types for the T20 match controller: FSM states, winner codes and
// the per-delivery run helper used by the innings counters.
package match_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      INN1  = 3'd1,
      BREAK = 3'd2,
      INN2  = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_T1   = 2'b01;
   localparam logic [1:0] WIN_T2   = 2'b10;
   localparam logic [1:0] WIN_TIE  = 2'b11;

   localparam int MAX_BALL_RUNS = 6;

   // Bat runs clamp at six (an input of 7 scores six); a wide/no-ball adds one.
   function automatic logic [3:0] ball_total(input logic [2:0] runs, input logic extra);
      logic [2:0] r;
      r = (runs > 3'(MAX_BALL_RUNS)) ? 3'(MAX_BALL_RUNS) : runs;
      return {1'b0, r} + {3'b000, extra};
   endfunction

endpackage

// File: rtl/innings_counter.sv
// One team's runs/balls/wickets. Exposes next-state values so the controller
// can decide an innings end on the same edge the counters update.
module innings_counter
   import match_pkg::*;
#(
   parameter int MAX_WICKETS = 10,
   parameter int RUN_W       = 9,
   parameter int BALL_W      = 7,
   parameter int WKT_W       = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              en,
   input  logic [2:0]        ball_runs,
   input  logic              ball_wicket,
   input  logic              ball_extra,
   output logic [RUN_W-1:0]  runs,
   output logic [BALL_W-1:0] balls,
   output logic [WKT_W-1:0]  wkts,
   output logic [RUN_W-1:0]  runs_nxt,
   output logic [BALL_W-1:0] balls_nxt,
   output logic [WKT_W-1:0]  wkts_nxt
);

   localparam int RW1 = RUN_W + 1;

   logic [RUN_W:0] run_sum;

   always_comb begin
      run_sum   = {1'b0, runs} + RW1'(ball_total(ball_runs, ball_extra));
      runs_nxt  = run_sum[RUN_W] ? '1 : run_sum[RUN_W-1:0];
      balls_nxt = (ball_extra || balls == '1) ? balls : balls + 1'b1;
      wkts_nxt  = (ball_wicket && wkts < WKT_W'(MAX_WICKETS)) ? wkts + 1'b1 : wkts;
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         runs  <= '0;
         balls <= '0;
         wkts  <= '0;
      end else if (en) begin
         runs  <= runs_nxt;
         balls <= balls_nxt;
         wkts  <= wkts_nxt;
      end
   end

endmodule

// File: rtl/match_result_fsm.sv
// Two-innings match controller: sequences IDLE/INN1/BREAK/INN2/DONE, ends
// innings on wicket/ball limits or a completed chase, and registers the result.
module match_result_fsm
   import match_pkg::*;
#(
   parameter int BALLS_PER_INN = 120,
   parameter int MAX_WICKETS   = 10,
   parameter int RUN_W         = 9,
   parameter int BALL_W        = 7,
   parameter int WKT_W         = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              ball_valid,
   input  logic [2:0]        ball_runs,
   input  logic              ball_wicket,
   input  logic              ball_extra,
   output logic [RUN_W-1:0]  team1_runs,
   output logic [WKT_W-1:0]  team1_wickets,
   output logic [BALL_W-1:0] team1_balls,
   output logic [RUN_W-1:0]  team2_runs,
   output logic [WKT_W-1:0]  team2_wickets,
   output logic [BALL_W-1:0] team2_balls,
   output logic [2:0]        state,
   output logic              innings_over,
   output logic              game_over,
   output logic              result_valid,
   output logic [1:0]        winner,
   output logic [RUN_W-1:0]  margin
);

   state_t st;

   logic [1:0]             en;
   logic                   clr;
   logic [1:0][RUN_W-1:0]  runs_q, runs_nxt;
   logic [1:0][BALL_W-1:0] balls_q, balls_nxt;
   logic [1:0][WKT_W-1:0]  wkts_q, wkts_nxt;
   logic [1:0]             limit_hit;
   logic                   chase_done;
   logic [1:0]             res_winner;
   logic [RUN_W-1:0]       res_margin;

   // Start is only a new match from IDLE/DONE; counters restart on that edge.
   assign en[0] = ball_valid && (st == INN1);
   assign en[1] = ball_valid && (st == INN2);
   assign clr   = start && (st == IDLE || st == DONE);

   for (genvar g = 0; g < 2; g++) begin : g_team
      innings_counter #(
         .MAX_WICKETS (MAX_WICKETS),
         .RUN_W       (RUN_W),
         .BALL_W      (BALL_W),
         .WKT_W       (WKT_W)
      ) u_cnt (
         .clk         (clk),
         .rst_n       (rst_n),
         .clr         (clr),
         .en          (en[g]),
         .ball_runs   (ball_runs),
         .ball_wicket (ball_wicket),
         .ball_extra  (ball_extra),
         .runs        (runs_q[g]),
         .balls       (balls_q[g]),
         .wkts        (wkts_q[g]),
         .runs_nxt    (runs_nxt[g]),
         .balls_nxt   (balls_nxt[g]),
         .wkts_nxt    (wkts_nxt[g])
      );
      assign limit_hit[g] = (wkts_nxt[g] == WKT_W'(MAX_WICKETS)) ||
                            (balls_nxt[g] == BALL_W'(BALLS_PER_INN));
   end

   assign chase_done = runs_nxt[1] > runs_q[0];

   // Result is judged on team2's post-delivery totals, matching the ending edge.
   always_comb begin
      res_winner = WIN_TIE;
      res_margin = '0;
      if (chase_done) begin
         res_winner = WIN_T2;
         res_margin = RUN_W'(MAX_WICKETS) - RUN_W'(wkts_nxt[1]);
      end else if (runs_q[0] > runs_nxt[1]) begin
         res_winner = WIN_T1;
         res_margin = runs_q[0] - runs_nxt[1];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st           <= IDLE;
         innings_over <= 1'b0;
         game_over    <= 1'b0;
         result_valid <= 1'b0;
         winner       <= WIN_NONE;
         margin       <= '0;
      end else begin
         innings_over <= 1'b0;
         case (st)
            IDLE:  if (start) st <= INN1;
            INN1:  if (en[0] && limit_hit[0]) begin
                      st           <= BREAK;
                      innings_over <= 1'b1;
                   end
            BREAK: if (start) st <= INN2;
            INN2:  if (en[1] && (limit_hit[1] || chase_done)) begin
                      st           <= DONE;
                      innings_over <= 1'b1;
                      game_over    <= 1'b1;
                      result_valid <= 1'b1;
                      winner       <= res_winner;
                      margin       <= res_margin;
                   end
            DONE:  if (start) begin
                      st           <= INN1;
                      game_over    <= 1'b0;
                      result_valid <= 1'b0;
                      winner       <= WIN_NONE;
                      margin       <= '0;
                   end
            default: st <= IDLE;
         endcase
      end
   end

   assign state         = st;
   assign team1_runs    = runs_q[0];
   assign team1_balls   = balls_q[0];
   assign team1_wickets = wkts_q[0];
   assign team2_runs    = runs_q[1];
   assign team2_balls   = balls_q[1];
   assign team2_wickets = wkts_q[1];

endmodule

// File: tb/tb_match_result_fsm.sv
// Scoreboard bench: stimulus queues the expected output snapshot for a given
// cycle; a negedge monitor pops and compares it against the DUT.
module tb_match_result_fsm;
   import match_pkg::*;

   typedef struct packed {
      logic [2:0] st;
      logic [8:0] r1;
      logic [3:0] w1;
      logic [6:0] b1;
      logic [8:0] r2;
      logic [3:0] w2;
      logic [6:0] b2;
      logic       io;
      logic       go;
      logic       rv;
      logic [1:0] win;
      logic [8:0] mar;
   } snap_t;

   typedef struct packed {
      int    tag;
      int    id;
      int    ph;
      snap_t s;
   } ent_t;

   logic       clk = 1'b0;
   logic       rst_n, start, ball_valid, ball_wicket, ball_extra;
   logic [2:0] ball_runs;
   logic [8:0] team1_runs, team2_runs, margin;
   logic [3:0] team1_wickets, team2_wickets;
   logic [6:0] team1_balls, team2_balls;
   logic [2:0] state;
   logic       innings_over, game_over, result_valid;
   logic [1:0] winner;

   int    cyc = 0;
   int    checks = 0;
   int    errors = 0;
   int    nid = 0;
   int    phase = 0;
   snap_t e;
   ent_t  q[$];

   match_result_fsm dut (
      .clk(clk), .rst_n(rst_n), .start(start), .ball_valid(ball_valid),
      .ball_runs(ball_runs), .ball_wicket(ball_wicket), .ball_extra(ball_extra),
      .team1_runs(team1_runs), .team1_wickets(team1_wickets), .team1_balls(team1_balls),
      .team2_runs(team2_runs), .team2_wickets(team2_wickets), .team2_balls(team2_balls),
      .state(state), .innings_over(innings_over), .game_over(game_over),
      .result_valid(result_valid), .winner(winner), .margin(margin)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic string fmt(input snap_t s);
      return $sformatf("st=%0d t1=%0d/%0d b%0d t2=%0d/%0d b%0d io=%0b go=%0b rv=%0b win=%0d mar=%0d",
                       s.st, s.r1, s.w1, s.b1, s.r2, s.w2, s.b2, s.io, s.go, s.rv, s.win, s.mar);
   endfunction

   // Monitor
   initial begin
      ent_t  ent;
      snap_t act;
      forever begin
         @(negedge clk);
         act = '{state, team1_runs, team1_wickets, team1_balls, team2_runs, team2_wickets,
                 team2_balls, innings_over, game_over, result_valid, winner, margin};
         while (q.size() > 0 && q[0].tag <= cyc) begin
            ent = q.pop_front();
            checks++;
            if (ent.tag != cyc || act !== ent.s) begin
               errors++;
               $display("FAIL test%0d chk%0d cyc%0d: got %s want %s", ent.ph, ent.id, cyc,
                        fmt(act), fmt(ent.s));
            end
         end
      end
   end

   task automatic push_exp();
      ent_t n;
      n.tag = cyc + 1;
      n.id  = nid;
      n.ph  = phase;
      n.s   = e;
      nid++;
      q.push_back(n);
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
      start = 1'b0; ball_valid = 1'b0; ball_runs = 3'd0; ball_wicket = 1'b0; ball_extra = 1'b0;
   endtask

   task automatic do_start(input logic [2:0] nst, input bit clear_all);
      if (clear_all) e = '0;
      e.st  = nst;
      start = 1'b1;
      push_exp();
      cycle();
   endtask

   // One delivery: expected counters follow the scoring rules by hand.
   task automatic deliver(input int team, input int r, input bit w, input bit x);
      int add;
      add = (r > 6) ? 6 : r;
      add = add + int'(x);
      if (team == 1) begin
         e.r1 = e.r1 + 9'(add);
         if (!x) e.b1 = e.b1 + 7'd1;
         if (w && e.w1 < 4'd10) e.w1 = e.w1 + 4'd1;
      end else begin
         e.r2 = e.r2 + 9'(add);
         if (!x) e.b2 = e.b2 + 7'd1;
         if (w && e.w2 < 4'd10) e.w2 = e.w2 + 4'd1;
      end
      ball_valid = 1'b1; ball_runs = 3'(r); ball_wicket = w; ball_extra = x;
      push_exp();
      cycle();
   endtask

   task automatic balls_n(input int team, input int r, input bit w, input bit x, input int n);
      for (int i = 0; i < n; i++) deliver(team, r, w, x);
   endtask

   task automatic end_inn1(input int r, input bit w);
      e.st = BREAK; e.io = 1'b1;
      deliver(1, r, w, 1'b0);
      e.io = 1'b0;
   endtask

   task automatic end_match(input int r, input bit w, input logic [1:0] win, input int mar);
      e.st = DONE; e.io = 1'b1; e.go = 1'b1; e.rv = 1'b1; e.win = win; e.mar = 9'(mar);
      deliver(2, r, w, 1'b0);
      e.io = 1'b0;
   endtask

   task automatic ignored_ball();
      ball_valid = 1'b1; ball_runs = 3'd4; ball_wicket = 1'b1;
      push_exp();
      cycle();
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; ball_valid = 1'b0; ball_runs = 3'd0;
      ball_wicket = 1'b0; ball_extra = 1'b0;
      e = '0;
      phase = 0;
      push_exp(); cycle();
      push_exp(); cycle();
      rst_n = 1'b1;

      // 120 legal dots end innings 1; team2 wins chase with a single
      phase = 2;
      do_start(INN1, 1'b1);
      balls_n(1, 0, 1'b0, 1'b0, 119);
      end_inn1(0, 1'b0);
      ignored_ball();
      ignored_ball();
      do_start(INN2, 1'b0);
      end_match(1, 1'b0, WIN_T2, 10);
      ignored_ball();

      // restart from DONE with a ball in the start cycle; 3 wides, 10 wickets
      phase = 3;
      ball_valid = 1'b1; ball_runs = 3'd6;
      do_start(INN1, 1'b1);
      balls_n(1, 0, 1'b0, 1'b1, 3);
      balls_n(1, 0, 1'b1, 1'b0, 9);
      end_inn1(0, 1'b1);
      do_start(INN2, 1'b0);
      balls_n(2, 0, 1'b1, 1'b0, 9);
      end_match(0, 1'b1, WIN_T1, 3);

      // 150 with 10th wicket on ball 120; chase 151/4 on ball 97
      phase = 4;
      do_start(INN1, 1'b1);
      balls_n(1, 0, 1'b1, 1'b0, 9);
      balls_n(1, 6, 1'b0, 1'b0, 25);
      balls_n(1, 0, 1'b0, 1'b0, 85);
      end_inn1(0, 1'b1);
      do_start(INN2, 1'b0);
      balls_n(2, 0, 1'b1, 1'b0, 4);
      balls_n(2, 6, 1'b0, 1'b0, 25);
      balls_n(2, 0, 1'b0, 1'b0, 67);
      end_match(1, 1'b0, WIN_T2, 6);
      ignored_ball();

      // tie on 160 after 120 balls each
      phase = 5;
      do_start(INN1, 1'b1);
      balls_n(1, 6, 1'b0, 1'b0, 26);
      deliver(1, 4, 1'b0, 1'b0);
      balls_n(1, 0, 1'b0, 1'b0, 92);
      end_inn1(0, 1'b0);
      do_start(INN2, 1'b0);
      balls_n(2, 6, 1'b0, 1'b0, 26);
      deliver(2, 4, 1'b0, 1'b0);
      balls_n(2, 0, 1'b0, 1'b0, 92);
      end_match(0, 1'b0, WIN_TIE, 0);

      // 180/5 beats all-out 120; bat input 7 scores six
      phase = 6;
      do_start(INN1, 1'b1);
      balls_n(1, 0, 1'b1, 1'b0, 5);
      balls_n(1, 7, 1'b0, 1'b0, 30);
      balls_n(1, 0, 1'b0, 1'b0, 84);
      end_inn1(0, 1'b0);
      do_start(INN2, 1'b0);
      balls_n(2, 6, 1'b0, 1'b0, 20);
      balls_n(2, 0, 1'b1, 1'b0, 9);
      end_match(0, 1'b1, WIN_T1, 60);
      do_start(INN1, 1'b1);

      // reset mid-INN2 at 140/3 vs 50/2
      phase = 1;
      balls_n(1, 6, 1'b0, 1'b0, 20);
      balls_n(1, 4, 1'b0, 1'b0, 5);
      balls_n(1, 0, 1'b1, 1'b0, 3);
      balls_n(1, 0, 1'b0, 1'b0, 91);
      end_inn1(0, 1'b0);
      do_start(INN2, 1'b0);
      balls_n(2, 6, 1'b0, 1'b0, 8);
      deliver(2, 2, 1'b0, 1'b0);
      balls_n(2, 0, 1'b1, 1'b0, 2);
      rst_n = 1'b0;
      e = '0;
      ignored_ball();
      rst_n = 1'b1;
      ignored_ball();

      cycle();
      cycle();
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
